// File: rtl/inst_fetch_pkg.sv
// Shared constants for the MIPS32 instruction fetch stage.
// Optional misaligned-fetch trapping is enabled with INST_FETCH_ALIGN_CHECK_EN.
package inst_fetch_pkg;

    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;
    localparam logic [WORD_WIDTH-1:0] INST_FETCH_RESET_PC = 32'h0000_0000;
    localparam int INST_FETCH_DEPTH = 2;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous register FIFO carrying fetched {instruction, pc} pairs toward decode.
// The head is read directly from storage, so a push is visible on the next cycle.
module inst_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [W-1:0]           push_inst,
    input  logic [W-1:0]           push_pc,
    input  logic                   pop,
    output logic [W-1:0]           head_inst,
    output logic [W-1:0]           head_pc,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  inst_mem [DEPTH];
    logic [W-1:0]  pc_mem   [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(DEPTH));
    assign count     = count_reg;
    assign pop_ok    = pop && !empty;
    // A full FIFO still takes a push when its head leaves in the same cycle.
    assign push_ok   = push && (!full || pop_ok);
    assign head_inst = inst_mem[rd_ptr_reg];
    assign head_pc   = pc_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok && !clear && !rst) begin
            inst_mem[wr_ptr_reg] <= push_inst;
            pc_mem[wr_ptr_reg]   <= push_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// MIPS32 IF stage: PC, in-order imem requests, response FIFO, redirect flush.
// Define INST_FETCH_ALIGN_CHECK_EN to trap misaligned PCs instead of forcing alignment.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int           W        = WORD_WIDTH,
    parameter logic [W-1:0] RESET_PC = W'(INST_FETCH_RESET_PC),
    parameter int           DEPTH    = INST_FETCH_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect_en,
    input  logic [W-1:0] redirect_pc,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [W-1:0] imem_rdata,
    output logic [W-1:0] inst,
    output logic [W-1:0] inst_pc,
    output logic         inst_valid,
    output logic         bubble_out,
    output logic         fetch_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Stale responses can pile up over back-to-back redirects, so give headroom.
    localparam int DW = CW + 3;

    logic [W-1:0]  pc_reg;
    logic [CW-1:0] outstanding_reg;
    logic [DW-1:0] drop_cnt_reg;
    logic [W-1:0]  pcq_mem [DEPTH];
    logic [AW-1:0] pcq_wr_reg;
    logic [AW-1:0] pcq_rd_reg;

    logic [W-1:0]  head_inst;
    logic [W-1:0]  head_pc;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic          misaligned;
    logic          fault_hold;
    logic [W-1:0]  load_pc;
    logic [W-1:0]  boot_pc;
    logic          pop;
    logic          accept;
    logic          resp_stale;
    logic          resp_live;
    logic          slot_free;
    logic [CW:0]   credit_used;
    logic          can_issue;

`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic fault_hold_reg;

    assign misaligned = (pc_reg[1:0] != 2'b00);
    assign fault_hold = fault_hold_reg;
    assign load_pc    = redirect_pc;
    assign boot_pc    = RESET_PC;

    always_ff @(posedge clk) begin
        if (rst || redirect_en) begin
            fault_hold_reg <= 1'b0;
        end else if (misaligned) begin
            fault_hold_reg <= 1'b1;
        end
    end
`else
    assign misaligned = 1'b0;
    assign fault_hold = 1'b0;
    assign load_pc    = redirect_pc & ~W'(3);
    assign boot_pc    = RESET_PC & ~W'(3);
`endif

    assign inst_valid  = !fifo_empty && !fault_hold;
    assign bubble_out  = !inst_valid;
    assign fetch_fault = fault_hold;
    assign inst        = inst_valid ? head_inst : W'(ZERO_WORD);
    assign inst_pc     = fault_hold ? pc_reg : (inst_valid ? head_pc : '0);
    assign imem_addr   = pc_reg;

    assign pop        = inst_valid && !stall;
    assign resp_stale = imem_rvalid && (drop_cnt_reg != '0);
    assign resp_live  = imem_rvalid && !resp_stale;

    // The head leaving this cycle frees its slot, which keeps 1 inst/cycle streaming.
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count} - (CW+1)'(pop);
    assign slot_free   = !fifo_full || pop;
    assign can_issue   = slot_free && (credit_used < (CW+1)'(DEPTH));
    assign imem_req    = !rst && !redirect_en && !fault_hold && !misaligned && can_issue;
    assign accept      = imem_req && imem_gnt;

    always_ff @(posedge clk) begin
        if (accept) begin
            pcq_mem[pcq_wr_reg] <= pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= boot_pc;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            pcq_wr_reg      <= '0;
            pcq_rd_reg      <= '0;
        end else if (redirect_en) begin
            // Everything still in flight is now stale, minus whatever lands right now.
            pc_reg          <= load_pc;
            outstanding_reg <= '0;
            drop_cnt_reg    <= drop_cnt_reg + DW'(outstanding_reg) - DW'(imem_rvalid);
            pcq_wr_reg      <= '0;
            pcq_rd_reg      <= '0;
        end else begin
            if (accept) begin
                pc_reg     <= pc_reg + W'(4);
                pcq_wr_reg <= pcq_wr_reg + AW'(1);
            end
            if (resp_live) begin
                pcq_rd_reg <= pcq_rd_reg + AW'(1);
            end
            if (resp_stale) begin
                drop_cnt_reg <= drop_cnt_reg - DW'(1);
            end
            outstanding_reg <= outstanding_reg + CW'(accept) - CW'(resp_live);
        end
    end

    inst_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_en),
        .push      (resp_live && !redirect_en),
        .push_inst (imem_rdata),
        .push_pc   (pcq_mem[pcq_rd_reg]),
        .pop       (pop),
        .head_inst (head_inst),
        .head_pc   (head_pc),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: in-order memory model plus a program-order stream reference.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int W = 32;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         redirect_en;
    logic [W-1:0] redirect_pc;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [W-1:0] imem_rdata;
    logic [W-1:0] inst;
    logic [W-1:0] inst_pc;
    logic         inst_valid;
    logic         bubble_out;
    logic         fetch_fault;

    always #5 clk = ~clk;

    inst_fetch #(.W(W), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .bubble_out  (bubble_out),
        .fetch_fault (fetch_fault)
    );

    typedef struct {
        logic [W-1:0] addr;
        int           due;
    } mreq_t;

    mreq_t        mq[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           pops = 0;
    int           lat_min = 1;
    int           lat_max = 1;
    logic [W-1:0] exp_pc;
    logic [W-1:0] next_req_addr;
`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic [W-1:0] align_mask = 32'hFFFF_FFFF;
`else
    logic [W-1:0] align_mask = 32'hFFFF_FFFC;
`endif

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic resp_due();
        return (mq.size() > 0) && (mq[0].due <= cyc);
    endfunction

    task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive this cycle's memory response, then let combinational outputs settle.
    task automatic present();
        if (resp_due()) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
    endtask

    // Per-cycle invariant checks and reference-model update, then move to the next cycle.
    task automatic advance();
        check_bit("bubble", bubble_out, !inst_valid);
        if (!inst_valid) check_word("nop_when_empty", inst, ZERO_WORD);
        if (rst) check_bit("no_req_in_rst", imem_req, 1'b0);
        else if (redirect_en) check_bit("no_req_in_redirect", imem_req, 1'b0);
        else if (imem_req) check_word("req_addr", imem_addr, next_req_addr);
        if (!rst && !redirect_en && inst_valid && !stall) begin
            check_word("stream_pc", inst_pc, exp_pc);
            check_word("stream_inst", inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (imem_rvalid) void'(mq.pop_front());
        if (rst) begin
            mq.delete();
            exp_pc = 32'h0;
            next_req_addr = 32'h0;
        end else if (redirect_en) begin
            exp_pc = redirect_pc & align_mask;
            next_req_addr = redirect_pc & align_mask;
        end else if (imem_req && imem_gnt) begin
            mq.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
            next_req_addr = next_req_addr + 32'd4;
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        bit seen;
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        exp_pc = '0; next_req_addr = '0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin present(); advance(); end

        // Reset state
        present();
        check_bit("rst_req", imem_req, 1'b0);
        check_word("rst_addr", imem_addr, 32'h0);
        check_word("rst_inst", inst, ZERO_WORD);
        check_word("rst_inst_pc", inst_pc, 32'h0);
        check_bit("rst_valid", inst_valid, 1'b0);
        check_bit("rst_bubble", bubble_out, 1'b1);
        check_bit("rst_fault", fetch_fault, 1'b0);
        advance();

        // Streaming with 1-cycle memory, then a 5-cycle stall
        rst = 1'b0; imem_gnt = 1'b1; lat_min = 1; lat_max = 1;
        for (int c = 0; c < 15; c++) begin
            stall = (c >= 6 && c <= 10);
            present();
            if (c == 0) begin
                check_bit("a_first_req", imem_req, 1'b1);
                check_word("a_first_addr", imem_addr, 32'h0);
                check_bit("a_valid_c0", inst_valid, 1'b0);
            end
            if (c == 1) check_bit("a_valid_c1", inst_valid, 1'b0);
            if (c == 2) begin
                check_bit("a_valid_c2", inst_valid, 1'b1);
                check_word("a_pc_c2", inst_pc, 32'h0);
            end
            if (c == 3) check_word("a_pc_c3", inst_pc, 32'h4);
            if (c == 4) check_word("a_pc_c4", inst_pc, 32'h8);
            if (c == 5) check_word("a_pc_c5", inst_pc, 32'hC);
            if (c == 7 || c == 10) begin
                check_bit("a_stall_req", imem_req, 1'b0);
                check_bit("a_stall_valid", inst_valid, 1'b1);
                check_word("a_stall_pc", inst_pc, 32'h10);
            end
            if (c == 12) check_word("a_resume_pc0", inst_pc, 32'h14);
            if (c == 13) check_word("a_resume_pc1", inst_pc, 32'h18);
            advance();
        end

        // Mid-operation reset, then latency-3 memory with a redirect over 2 outstanding
        rst = 1'b1; stall = 1'b0; present(); advance();
        rst = 1'b0; lat_min = 3; lat_max = 3;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            redirect_en = (c < 6) && (mq.size() == 2) && (exp_pc == 32'h0);
            redirect_pc = 32'h100;
            present();
            if (c > 0 && !seen && inst_valid) begin
                seen = 1'b1;
                check_word("c_first_after_redirect", inst_pc, 32'h100);
            end
            advance();
            if (c == 2) begin
                check_word("c_redirect_taken", exp_pc, 32'h100);
            end
        end
        check_bit("c_valid_seen", seen, 1'b1);
        redirect_en = 1'b0;

        // Redirect coinciding with a response and a stall
        lat_min = 1; lat_max = 1;
        for (int c = 0; c < 6; c++) begin present(); advance(); end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (resp_due()) begin
                seen = 1'b1;
                stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h40;
            end
            present();
            advance();
        end
        check_bit("d_resp_found", seen, 1'b1);
        redirect_en = 1'b0;
        present();
        check_bit("d_fifo_empty", inst_valid, 1'b0);
        check_word("d_pc_target", imem_addr, 32'h40);
        check_bit("d_req", imem_req, 1'b1);
        advance();
        stall = 1'b0;
        for (int c = 0; c < 6; c++) begin present(); advance(); end

        // PC wrap-around
        redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC; present(); advance();
        redirect_en = 1'b0;
        present();
        check_word("e_addr_top", imem_addr, 32'hFFFF_FFFC);
        advance();
        present();
        check_bit("e_req_wrap", imem_req, 1'b1);
        check_word("e_addr_wrap", imem_addr, 32'h0);
        advance();
        for (int c = 0; c < 6; c++) begin present(); advance(); end

`ifdef INST_FETCH_ALIGN_CHECK_EN
        // Misaligned redirect traps until the next redirect
        redirect_en = 1'b1; redirect_pc = 32'h102; present(); advance();
        redirect_en = 1'b0;
        present(); check_bit("f_no_req", imem_req, 1'b0); advance();
        present();
        check_bit("f_fault", fetch_fault, 1'b1);
        check_bit("f_valid", inst_valid, 1'b0);
        check_word("f_fault_pc", inst_pc, 32'h102);
        check_bit("f_no_req_held", imem_req, 1'b0);
        advance();
        redirect_en = 1'b1; redirect_pc = 32'h200; present(); advance();
        redirect_en = 1'b0;
        present();
        check_bit("f_fault_clear", fetch_fault, 1'b0);
        check_bit("f_resume_req", imem_req, 1'b1);
        check_word("f_resume_addr", imem_addr, 32'h200);
        advance();
`else
        // Misaligned redirect target is forced to a word boundary
        redirect_en = 1'b1; redirect_pc = 32'h102; present(); advance();
        redirect_en = 1'b0;
        present();
        check_word("f_forced_align", imem_addr, 32'h100);
        check_bit("f_fault_tied", fetch_fault, 1'b0);
        advance();
`endif
        for (int c = 0; c < 6; c++) begin present(); advance(); end

        // Randomised traffic
        pops = 0; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(99) == 0);
            stall       = ($urandom_range(99) < 30);
            imem_gnt    = ($urandom_range(99) < 70);
            redirect_en = ($urandom_range(99) < 5);
            redirect_pc = $urandom & align_mask;
            present();
            advance();
        end
        check_bit("rand_progress", (pops >= 40), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch (IF) stage of the MIPS32 pipeline. Holds the PC, issues in-order word requests to instruction memory, buffers returned instructions in a small FIFO, and presents one instruction per cycle to the decode stage. The PC is redirected on taken branches and jumps, and the stage discards any responses still in flight from before the redirect.

## Interface
Parameters:
- W, `WORD_WIDTH: data/address width.
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- DEPTH, 2: instruction FIFO entries; must be a power of 2, ≥2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  decode is holding; do not pop.
- redirect_en  in  1  taken branch/jump this cycle.
- redirect_pc  in  W  new PC target.
- imem_req  out  1  request valid.
- imem_addr  out  W  word address (bits [1:0] always 0).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in order, ≥1 cycle after grant.
- imem_rdata  in  W  response instruction.
- inst  out  W  instruction to decode.
- inst_pc  out  W  PC of `inst`.
- inst_valid  out  1  `inst`/`inst_pc` meaningful.
- bubble_out  out  1  equals !inst_valid; drives the decoder's bubble input.
- fetch_fault  out  1  misaligned fetch (macro only).

## Operation
- Counters: `outstanding` counts granted requests without a response (0..DEPTH). `count` is FIFO occupancy. `drop_cnt` counts stale responses still to discard.
- Request rule: imem_req = !rst && !redirect_en && !fault_hold && (outstanding + count < DEPTH). On a grant, pc advances by 4 and outstanding increments.
- Response: if drop_cnt > 0, the response is discarded and drop_cnt decrements. Otherwise {imem_rdata, req_pc} is pushed into the FIFO. The request PC travels in a DEPTH-entry PC queue in parallel with the requests.
- Pop: when inst_valid && !stall. A push and a pop in the same cycle are both legal, including when the FIFO is full; the credit rule prevents overflow.
- Output: FIFO head. When the FIFO is empty, inst = `ZERO_WORD` (sll $0, a NOP) and inst_valid = 0.
- Redirect (highest priority; overrides stall, push and request):
  - pc <= redirect_pc.
  - The FIFO and PC queue are cleared.
  - drop_cnt <= drop_cnt + outstanding − imem_rvalid. A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle.
- Wrap-around: the PC increments modulo 2^W with no flag.

## Timing
- Reset values: pc = RESET_PC; outstanding = count = drop_cnt = 0; imem_req = 0; imem_addr = RESET_PC; inst = `ZERO_WORD`; inst_pc = 0; inst_valid = 0; bubble_out = 1; fetch_fault = 0.
- First imem_req is asserted in the first cycle after rst falls.
- A response in cycle N appears on inst/inst_valid in cycle N+1 (registered FIFO). Redirect-to-request latency is 1 cycle.
- With 1-cycle memory latency, gnt = 1 and no stall, throughput is 1 instruction/cycle.
- Reset asserted mid-operation: all state returns to reset values on the next edge. Responses to pre-reset requests are the memory's responsibility.

## Configuration
- INST_FETCH_ALIGN_CHECK_EN defined:
  - When pc[1:0] ≠ 0 at request time, no request is issued.
  - fault_hold and fetch_fault are set (sticky) and inst_pc holds the faulting PC with inst_valid = 0.
  - Both clear on redirect_en or rst.
- INST_FETCH_ALIGN_CHECK_EN undefined: pc[1:0] is forced to 0 when loaded, and fetch_fault is tied 0.

## Structure
- Add `RESET_PC` and `INST_FETCH_DEPTH` to defines.v. Reuse `WORD_WIDTH` and `ZERO_WORD`.
- One sub-module, inst_fifo: a synchronous DEPTH-entry FIFO carrying {inst, pc}, with push, pop, clear, full, empty and count.

## Test plan
- Reset, then 1-cycle memory with gnt = 1: inst_pc sequence 0x0, 0x4, 0x8 on consecutive cycles; first inst_valid appears 2 cycles after rst falls.
- Hold stall = 1 for 5 cycles: the FIFO fills to 2, imem_req drops, and inst_pc stays 0x4. After stall is released the sequence continues 0x8, 0xC with no loss or duplicate.
- Memory latency 3, redirect_en with redirect_pc = 0x100 while 2 requests are outstanding: both stale responses are dropped, and the next valid inst_pc is 0x100.
- Redirect in the same cycle as imem_rvalid and stall: the response is dropped, the FIFO is empty next cycle, and pc = target.
- PC = 0xFFFF_FFFC: the next request address is 0x0000_0000.
- With the macro, redirect_pc = 0x102: fetch_fault = 1, no imem_req, inst_valid = 0. A redirect to 0x200 clears the fault and fetch resumes.
